// File: rtl/ram_ctrl.sv
// Load-then-serve controller in front of the 64x10 registered-read block RAM.
// Optional load checksum on o_ld_sum is built when RAM_CTRL_CHECKSUM_EN is defined.
module ram_ctrl #(
    parameter int SIZE  = 6,
    parameter int DEPTH = 64
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            i_ld_valid,
    input  logic [9:0]      i_ld_data,
    input  logic            i_ld_last,
    output logic            o_ld_ready,
    output logic            o_ld_done,
    output logic [9:0]      o_ld_sum,
    input  logic            i_reload,
    input  logic            i_cpu_req,
    input  logic            i_cpu_we,
    input  logic [SIZE-1:0] i_cpu_addr,
    input  logic [9:0]      i_cpu_wdata,
    output logic            o_cpu_ready,
    output logic            o_rd_valid,
    output logic [9:0]      o_rd_data,
    output logic            o_ram_we,
    output logic [SIZE-1:0] o_ram_addr,
    output logic [9:0]      o_ram_wdata,
    input  logic [9:0]      i_ram_data
);

    typedef enum logic [0:0] {
        ST_LOAD = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    localparam logic [SIZE-1:0] LAST_ADDR = SIZE'(DEPTH - 1);
    localparam logic [SIZE-1:0] PTR_ONE   = {{(SIZE-1){1'b0}}, 1'b1};
    localparam logic [SIZE-1:0] PTR_ZERO  = {SIZE{1'b0}};

    state_t          state_r;
    logic [SIZE-1:0] ld_ptr_r;
    logic            ld_done_r;
    logic            ram_we_r;
    logic [SIZE-1:0] ram_addr_r;
    logic [9:0]      ram_wdata_r;
    logic            rd_pend_r;
    logic            rd_valid_r;
    logic            ld_final_s;

    // The final word is either flagged by the source or lands in the top address.
    assign ld_final_s  = i_ld_last | (ld_ptr_r == LAST_ADDR);

    assign o_ld_ready  = (state_r == ST_LOAD);
    assign o_cpu_ready = (state_r == ST_RUN) & ~i_reload;
    assign o_ld_done   = ld_done_r;
    assign o_rd_valid  = rd_valid_r;
    assign o_rd_data   = i_ram_data;
    assign o_ram_we    = ram_we_r;
    assign o_ram_addr  = ram_addr_r;
    assign o_ram_wdata = ram_wdata_r;

    // Mode FSM, load pointer, registered RAM drive and two-stage read-valid pipe.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_r     <= ST_LOAD;
            ld_ptr_r    <= PTR_ZERO;
            ld_done_r   <= 1'b0;
            ram_we_r    <= 1'b0;
            ram_addr_r  <= PTR_ZERO;
            ram_wdata_r <= 10'd0;
            rd_pend_r   <= 1'b0;
            rd_valid_r  <= 1'b0;
        end else begin
            ram_we_r   <= 1'b0;
            rd_pend_r  <= 1'b0;
            // RAM registers the word one edge after the address; valid follows it.
            rd_valid_r <= rd_pend_r;
            case (state_r)
                ST_LOAD: begin
                    if (i_ld_valid) begin
                        ram_we_r    <= 1'b1;
                        ram_addr_r  <= ld_ptr_r;
                        ram_wdata_r <= i_ld_data;
                        if (ld_final_s) begin
                            state_r   <= ST_RUN;
                            ld_done_r <= 1'b1;
                        end else begin
                            ld_ptr_r  <= ld_ptr_r + PTR_ONE;
                        end
                    end else begin
                        ld_ptr_r <= ld_ptr_r;
                    end
                end
                ST_RUN: begin
                    if (i_reload) begin
                        state_r   <= ST_LOAD;
                        ld_ptr_r  <= PTR_ZERO;
                        ld_done_r <= 1'b0;
                    end else if (i_cpu_req) begin
                        ram_addr_r <= i_cpu_addr;
                        if (i_cpu_we) begin
                            ram_we_r    <= 1'b1;
                            ram_wdata_r <= i_cpu_wdata;
                        end else begin
                            rd_pend_r <= 1'b1;
                        end
                    end else begin
                        ld_ptr_r <= ld_ptr_r;
                    end
                end
                default: begin
                    state_r   <= ST_LOAD;
                    ld_ptr_r  <= PTR_ZERO;
                    ld_done_r <= 1'b0;
                end
            endcase
        end
    end

`ifdef RAM_CTRL_CHECKSUM_EN
    logic [9:0] ld_sum_r;
    logic       ld_acc_s;
    logic       reload_s;

    assign ld_acc_s = (state_r == ST_LOAD) & i_ld_valid;
    assign reload_s = (state_r == ST_RUN) & i_reload;
    assign o_ld_sum = ld_sum_r;

    // Modulo-1024 running sum of the words accepted in the current load.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            ld_sum_r <= 10'd0;
        end else if (reload_s) begin
            ld_sum_r <= 10'd0;
        end else if (ld_acc_s) begin
            ld_sum_r <= ld_sum_r + i_ld_data;
        end else begin
            ld_sum_r <= ld_sum_r;
        end
    end
`else
    assign o_ld_sum = 10'd0;
`endif

endmodule

// File: doc/ram_ctrl.md
# ram_ctrl

Single-port controller sitting directly upstream of the 64x10 block RAM (`blram`). It owns the RAM's `i_we`/`i_addr`/`i_ram_data_in` pins and consumes its `o_ram_data_out`. After reset it fills the RAM from a valid/ready load stream; it then serves pipelined CPU read/write requests, absorbing the RAM's one-cycle registered-read latency.

## Interface
- `SIZE`, 6, address width; must match the RAM.
- `DEPTH`, 64, word count; equals 2**SIZE.
- `clk`  in  1  rising-edge clock.
- `rst`  in  1  asynchronous, active-low reset.
- `i_ld_valid`  in  1  load word present.
- `i_ld_data`  in  10  load word.
- `i_ld_last`  in  1  qualifies the final load word; sampled with `i_ld_valid`.
- `o_ld_ready`  out  1  controller accepts a load word this cycle.
- `o_ld_done`  out  1  load complete; level signal.
- `o_ld_sum`  out  10  load checksum (see Configuration).
- `i_reload`  in  1  single-cycle pulse that re-enters LOAD.
- `i_cpu_req`  in  1  CPU access request.
- `i_cpu_we`  in  1  1 = write, 0 = read.
- `i_cpu_addr`  in  SIZE  CPU address.
- `i_cpu_wdata`  in  10  CPU write data.
- `o_cpu_ready`  out  1  CPU request accepted this cycle.
- `o_rd_valid`  out  1  `o_rd_data` holds the requested word.
- `o_rd_data`  out  10  read data; combinational copy of `i_ram_data`.
- `o_ram_we`, `o_ram_addr[SIZE-1:0]`, `o_ram_wdata[9:0]`  out  registered RAM drive.
- `i_ram_data`  in  10  RAM `o_ram_data_out`.

## Operation
- States: LOAD (reset state), RUN.
- LOAD:
  - `o_ld_ready`=1 and `o_cpu_ready`=0.
  - Each `i_ld_valid` word is written at `ld_ptr`, which starts at 0 and increments by 1.
  - The state moves to RUN after the word with `i_ld_last`=1, or after the word at address DEPTH-1, whichever comes first. `ld_ptr` never wraps.
  - `o_ld_done` is set on that transition.
- RUN:
  - `o_ld_ready`=0 and `o_cpu_ready`=1.
  - `i_cpu_req` with `i_cpu_we`=1 writes `i_cpu_wdata`.
  - `i_cpu_req` with `i_cpu_we`=0 issues a read.
  - One access per cycle. Back-to-back reads are fully pipelined.
- `i_reload` in RUN:
  - Next state is LOAD, `ld_ptr` goes to 0, `o_ld_done` clears, and the checksum clears.
  - A CPU request in the same cycle is not accepted (`o_cpu_ready`=0 that cycle).
  - A read already issued still produces its `o_rd_valid`.
  - `i_reload` in LOAD is ignored.
- Idle cycles (no accepted op): `o_ram_we`=0; `o_ram_addr` and `o_ram_wdata` hold their last values.
- Reset (asserted asynchronously at any time):
  - State=LOAD, `ld_ptr`=0.
  - `o_ram_we`=0, `o_ram_addr`=0, `o_ram_wdata`=0.
  - `o_rd_valid`=0, `o_ld_done`=0, `o_ld_sum`=0.
  - Any in-flight read is dropped.

## Timing
- Handshake: a transfer happens on a rising edge where valid/req and ready are both high. `o_ld_ready` and `o_cpu_ready` are functions of state and `i_reload` only; they never depend on `i_ld_valid` or `i_cpu_req`.
- Accept at edge E0: `o_ram_we`/`o_ram_addr`/`o_ram_wdata` update at E0.
  - Write: the RAM commits the word at E1.
  - Read: the RAM registers data at E1, and `o_rd_valid`=1 for the single cycle E1..E2.
- Read latency is 2 edges from acceptance, with throughput of one read per cycle.
- Read-after-write to the same address in the next cycle returns the new data.
- Write then read in consecutive cycles needs no stall.
- `o_ld_done` rises at the edge that accepts the final load word. The first CPU access can be accepted on the following edge.

## Configuration
- `RAM_CTRL_CHECKSUM_EN` defined:
  - `o_ld_sum` is the modulo-1024 sum of all words accepted in the current LOAD.
  - It updates at each accepting edge and holds in RUN.
  - It clears on reset and on an accepted `i_reload`.
- Undefined: `o_ld_sum` is tied to 0 and no accumulator is built.

## Test plan
- Reset release, stream 0x001..0x040 with `i_ld_last` on word 64. Required: `o_ld_ready`=1 throughout; 64 writes to addresses 0..63; `o_ld_done`=1 after word 64; with the macro, `o_ld_sum`=0x020 (2080 mod 1024).
- Load 3 words 0x3FF, 0x155, 0x2AA with `i_ld_last` on the third, then read addresses 0,1,2 back-to-back. Required: `o_rd_valid` on 3 consecutive cycles starting 2 edges after the first accept, with data 0x3FF, 0x155, 0x2AA; `o_ld_sum`=0x3FE.
- In RUN: write 0x123 to address 5, then read address 5 the next cycle. Required: `o_rd_data`=0x123.
- In RUN: issue a read of address 2, then pulse `i_reload` the next cycle. Required: `o_rd_valid` still fires with the address-2 data; `o_cpu_ready`=0 in the reload cycle; `o_ld_done`=0; `o_ld_ready`=1 afterwards; the next load word goes to address 0.
- Assert `rst` low mid-load, after 10 words. Required: all outputs return to reset values immediately, without a clock edge; the next load word is written to address 0.
- Drive `i_cpu_req` during LOAD. Required: `o_cpu_ready`=0 and no RAM write from the CPU port.
